// File: rtl/lsu_req_arbiter.sv
// N-channel LSU request arbiter: fixed-priority or round-robin selection into a registered
// request slot, with per-channel RMW word locks and starvation promotion.
module lsu_req_arbiter #(
    parameter int  N_CH       = 2,
    parameter int  AW         = 16,
    parameter int  DW         = 16,
    parameter int  TW         = 2,
    parameter int  MODE       = 0,
    parameter int  STARVE_LIM = 8,
    localparam int CW         = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               a_rst,
    input  logic [N_CH-1:0]    ch_req,
    input  logic [N_CH*AW-1:0] ch_addr,
    input  logic [N_CH*DW-1:0] ch_data,
    input  logic [N_CH-1:0]    ch_width,
    input  logic [N_CH-1:0]    ch_cmd,
    input  logic [N_CH*TW-1:0] ch_tag,
    input  logic [N_CH-1:0]    ch_lock,
    input  logic [N_CH-1:0]    ch_unlock,
    output logic [N_CH-1:0]    ch_grant,
    output logic [N_CH-1:0]    ch_deny,
    output logic [AW-1:0]      rq_addr,
    output logic [DW-1:0]      rq_data,
    output logic               rq_width,
    output logic               rq_cmd,
    output logic [CW+TW-1:0]   rq_tag,
    output logic               rq_start,
    input  logic               rq_hold
);
    localparam int            SW  = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

    logic             start_q, start_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    data_q, data_d;
    logic             width_q, width_d;
    logic             cmd_q, cmd_d;
    logic [CW+TW-1:0] tag_q, tag_d;
    logic [N_CH-1:0]  lock_v_q, lock_v_d;
    logic [AW-2:0]    lock_a_q [N_CH];
    logic [AW-2:0]    lock_a_d [N_CH];
    logic [SW-1:0]    cnt_q [N_CH];
    logic [SW-1:0]    cnt_d [N_CH];
    logic [CW-1:0]    rr_q, rr_d;

    logic [N_CH-1:0]  elig;
    logic             free, win_v;
    logic [CW-1:0]    win;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;
    logic             sel_width, sel_cmd, sel_lock;
    logic [TW-1:0]    sel_tag;

    // Deny compares against registered locks only, so a same-cycle unlock still denies.
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            ch_deny[i] = 1'b0;
            for (int unsigned j = 0; j < N_CH; j++) begin
                if (j != i && lock_v_q[j] && lock_a_q[j] == ch_addr[i*AW+1 +: AW-1])
                    ch_deny[i] = 1'b1;
            end
            ch_deny[i] = ch_deny[i] & ch_req[i] & a_rst;
        end
    end

    assign elig = ch_req & ~ch_deny;
    assign free = ~start_q | ~rq_hold;

    always_comb begin
        int unsigned best;
        int unsigned d;
        logic        starve_hit;
        win_v      = 1'b0;
        win        = '0;
        best       = N_CH;
        d          = 0;
        starve_hit = 1'b0;
        if (MODE == 0) begin
            // Ascending scan: once a starved channel is taken only a higher starved one overrides.
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (elig[i] && (cnt_q[i] == LIM || !starve_hit)) begin
                    win   = CW'(i);
                    win_v = 1'b1;
                    if (cnt_q[i] == LIM) starve_hit = 1'b1;
                end
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (elig[i]) begin
                    d = (i + N_CH - 32'(rr_q) - 1) % N_CH;
                    if (d < best) begin
                        best  = d;
                        win   = CW'(i);
                        win_v = 1'b1;
                    end
                end
            end
        end
        win_v    = win_v & free & a_rst;
        ch_grant = win_v ? ({{(N_CH-1){1'b0}}, 1'b1} << win) : '0;
    end

    always_comb begin
        sel_addr  = '0;
        sel_data  = '0;
        sel_width = 1'b0;
        sel_cmd   = 1'b0;
        sel_lock  = 1'b0;
        sel_tag   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (ch_grant[i]) begin
                sel_addr  = ch_addr[i*AW +: AW];
                sel_data  = ch_data[i*DW +: DW];
                sel_width = ch_width[i];
                sel_cmd   = ch_cmd[i];
                sel_lock  = ch_lock[i];
                sel_tag   = ch_tag[i*TW +: TW];
            end
        end
    end

    always_comb begin
        start_d  = win_v | (start_q & rq_hold);
        addr_d   = win_v ? sel_addr : addr_q;
        data_d   = win_v ? sel_data : data_q;
        width_d  = win_v ? sel_width : width_q;
        cmd_d    = win_v ? sel_cmd : cmd_q;
        tag_d    = win_v ? {win, sel_tag} : tag_q;
        rr_d     = (MODE == 1 && win_v) ? win : rr_q;
        lock_v_d = lock_v_q & ~ch_unlock;
        for (int unsigned i = 0; i < N_CH; i++) begin
            lock_a_d[i] = lock_a_q[i];
            cnt_d[i]    = (elig[i] && !ch_grant[i])
                        ? ((cnt_q[i] == LIM) ? LIM : cnt_q[i] + SW'(1)) : '0;
        end
        if (win_v) begin
            if (!sel_cmd && sel_lock) begin
                lock_v_d[win] = 1'b1;
                lock_a_d[win] = sel_addr[AW-1:1];
            end else if (sel_cmd && lock_a_q[win] == sel_addr[AW-1:1]) begin
                lock_v_d[win] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!a_rst) begin
            start_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            width_q  <= 1'b0;
            cmd_q    <= 1'b0;
            tag_q    <= '0;
            rr_q     <= '0;
            lock_v_q <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                lock_a_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            start_q  <= start_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            width_q  <= width_d;
            cmd_q    <= cmd_d;
            tag_q    <= tag_d;
            rr_q     <= rr_d;
            lock_v_q <= lock_v_d;
            for (int unsigned i = 0; i < N_CH; i++) begin
                lock_a_q[i] <= lock_a_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    assign rq_start = start_q;
    assign rq_addr  = addr_q;
    assign rq_data  = data_q;
    assign rq_width = width_q;
    assign rq_cmd   = cmd_q;
    assign rq_tag   = tag_q;

endmodule

// File: tb/tb_lsu_req_arbiter.sv
// Bench for lsu_req_arbiter: a 2-channel fixed-priority instance and a 4-channel round-robin
// instance share one stimulus set, selected by sel, and are checked against a cycle model.
module tb_lsu_req_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, hold, sel;
    logic          req [4];
    logic          width [4];
    logic          cmd [4];
    logic          lock [4];
    logic          unlock [4];
    logic [AW-1:0] addr [4];
    logic [DW-1:0] data [4];
    logic [TW-1:0] tag [4];

    // instance 0: N_CH=2, MODE=0, STARVE_LIM=3
    logic [1:0] r0, w0, c0, l0, u0, g0, dn0;
    logic [2*AW-1:0] a0;
    logic [2*DW-1:0] d0;
    logic [2*TW-1:0] t0;
    logic [AW-1:0] qa0;
    logic [DW-1:0] qd0;
    logic qw0, qc0, qs0, h0;
    logic [2:0] qt0;
    // instance 1: N_CH=4, MODE=1
    logic [3:0] r1, w1, c1, l1, u1, g1, dn1;
    logic [4*AW-1:0] a1;
    logic [4*DW-1:0] d1;
    logic [4*TW-1:0] t1;
    logic [AW-1:0] qa1;
    logic [DW-1:0] qd1;
    logic qw1, qc1, qs1, h1;
    logic [3:0] qt1;

    always_comb begin
        r0 = '0; w0 = '0; c0 = '0; l0 = '0; u0 = '0; a0 = '0; d0 = '0; t0 = '0;
        r1 = '0; w1 = '0; c1 = '0; l1 = '0; u1 = '0; a1 = '0; d1 = '0; t1 = '0;
        for (int i = 0; i < 2; i++) if (!sel) begin
            r0[i] = req[i]; w0[i] = width[i]; c0[i] = cmd[i]; l0[i] = lock[i]; u0[i] = unlock[i];
            a0[i*AW +: AW] = addr[i]; d0[i*DW +: DW] = data[i]; t0[i*TW +: TW] = tag[i];
        end
        for (int i = 0; i < 4; i++) if (sel) begin
            r1[i] = req[i]; w1[i] = width[i]; c1[i] = cmd[i]; l1[i] = lock[i]; u1[i] = unlock[i];
            a1[i*AW +: AW] = addr[i]; d1[i*DW +: DW] = data[i]; t1[i*TW +: TW] = tag[i];
        end
    end
    assign h0 = hold & ~sel;
    assign h1 = hold & sel;

    lsu_req_arbiter #(.N_CH(2), .AW(AW), .DW(DW), .TW(TW), .MODE(0), .STARVE_LIM(3)) dut0 (
        .clk(clk), .a_rst(rst_n), .ch_req(r0), .ch_addr(a0), .ch_data(d0), .ch_width(w0),
        .ch_cmd(c0), .ch_tag(t0), .ch_lock(l0), .ch_unlock(u0), .ch_grant(g0), .ch_deny(dn0),
        .rq_addr(qa0), .rq_data(qd0), .rq_width(qw0), .rq_cmd(qc0), .rq_tag(qt0),
        .rq_start(qs0), .rq_hold(h0));

    lsu_req_arbiter #(.N_CH(4), .AW(AW), .DW(DW), .TW(TW), .MODE(1), .STARVE_LIM(8)) dut1 (
        .clk(clk), .a_rst(rst_n), .ch_req(r1), .ch_addr(a1), .ch_data(d1), .ch_width(w1),
        .ch_cmd(c1), .ch_tag(t1), .ch_lock(l1), .ch_unlock(u1), .ch_grant(g1), .ch_deny(dn1),
        .rq_addr(qa1), .rq_data(qd1), .rq_width(qw1), .rq_cmd(qc1), .rq_tag(qt1),
        .rq_start(qs1), .rq_hold(h1));

    logic [3:0]    o_grant, o_deny, o_tag;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;
    logic          o_width, o_cmd, o_start;
    assign o_grant = sel ? g1 : {2'b00, g0};
    assign o_deny  = sel ? dn1 : {2'b00, dn0};
    assign o_tag   = sel ? qt1 : {1'b0, qt0};
    assign o_addr  = sel ? qa1 : qa0;
    assign o_data  = sel ? qd1 : qd0;
    assign o_width = sel ? qw1 : qw0;
    assign o_cmd   = sel ? qc1 : qc0;
    assign o_start = sel ? qs1 : qs0;

    // reference model state
    int            n, mode, lim, rr, win;
    bit            lv [4];
    logic [AW-2:0] la [4];
    int            cnt [4];
    bit            ms, mw, mc;
    int            ma, md, mt;
    logic [31:0]   s_grant, s_deny, s_tag, s_addr, s_start;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic reset_model();
        rr = 0; ms = 0; ma = 0; md = 0; mw = 0; mc = 0; mt = 0;
        for (int i = 0; i < 4; i++) begin lv[i] = 0; la[i] = '0; cnt[i] = 0; end
    endtask

    // One clock: predict and compare at negedge, advance the model at posedge.
    task automatic cyc();
        bit          el [4];
        logic [31:0] eg, ed;
        @(negedge clk);
        ed = 0;
        for (int i = 0; i < n; i++) begin
            if (rst_n && req[i])
                for (int j = 0; j < n; j++)
                    if (j != i && lv[j] && la[j] == addr[i][AW-1:1]) ed[i] = 1'b1;
            el[i] = req[i] && !ed[i];
        end
        win = -1;
        if (rst_n && (!ms || !hold)) begin
            if (mode == 0) begin
                for (int i = 0; i < n; i++) if (el[i]) win = i;
                for (int i = 0; i < n; i++) if (el[i] && cnt[i] == lim) win = i;
            end else begin
                for (int k = 1; k <= n; k++)
                    if (win < 0 && el[(rr + k) % n]) win = (rr + k) % n;
            end
        end
        eg = (win >= 0) ? (32'd1 << win) : 32'd0;
        s_grant = 32'(o_grant); s_deny = 32'(o_deny); s_tag = 32'(o_tag);
        s_addr = 32'(o_addr); s_start = 32'(o_start);
        chk("grant", s_grant, eg);
        chk("deny", s_deny, ed);
        chk("rq_start", s_start, 32'(ms));
        if (ms) begin
            chk("rq_addr", s_addr, ma);
            chk("rq_data", 32'(o_data), md);
            chk("rq_width", 32'(o_width), 32'(mw));
            chk("rq_cmd", 32'(o_cmd), 32'(mc));
            chk("rq_tag", s_tag, mt);
        end
        @(posedge clk);
        if (!rst_n) reset_model();
        else begin
            for (int i = 0; i < n; i++) begin
                cnt[i] = (el[i] && i != win) ? ((cnt[i] < lim) ? cnt[i] + 1 : lim) : 0;
                if (unlock[i]) lv[i] = 0;
            end
            if (win >= 0) begin
                if (!cmd[win] && lock[win]) begin
                    lv[win] = 1; la[win] = addr[win][AW-1:1];
                end else if (cmd[win] && la[win] == addr[win][AW-1:1]) lv[win] = 0;
                if (mode == 1) rr = win;
                ms = 1; ma = int'(addr[win]); md = int'(data[win]);
                mw = width[win]; mc = cmd[win]; mt = (win << TW) | int'(tag[win]);
            end else if (ms && !hold) ms = 0;
        end
        #1;
    endtask

    task automatic retire();
        if (win >= 0) req[win] = 1'b0;
    endtask

    // Requests stay stable until granted; locks are only raised when the channel holds none.
    task automatic rnd();
        for (int i = 0; i < n; i++) begin
            if (!req[i] || win == i) begin
                req[i]   = 1'($urandom_range(0, 1));
                addr[i]  = 16'(16'h1000 + $urandom_range(0, 7));
                data[i]  = 16'($urandom);
                width[i] = 1'($urandom_range(0, 1));
                cmd[i]   = 1'($urandom_range(0, 1));
                tag[i]   = 2'($urandom_range(0, 3));
                lock[i]  = !cmd[i] && !lv[i] && ($urandom_range(0, 1) == 1);
            end
            unlock[i] = ($urandom_range(0, 7) == 0);
        end
        hold  = ($urandom_range(0, 2) == 0);
        rst_n = ($urandom_range(0, 63) != 0);
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0; sel = 1'b0;
        n = 2; mode = 0; lim = 3; win = -1;
        for (int i = 0; i < 4; i++) begin
            req[i] = 0; width[i] = 0; cmd[i] = 0; lock[i] = 0; unlock[i] = 0;
            addr[i] = '0; data[i] = '0; tag[i] = '0;
        end
        reset_model();
        @(posedge clk); #1;

        // T1: reset holds everything low even with requests pending
        req[0] = 1; req[1] = 1; addr[0] = 16'h0100; addr[1] = 16'h0200;
        data[0] = 16'hAAAA; data[1] = 16'h5555; tag[0] = 2'd1; tag[1] = 2'd2;
        cyc();
        chk("t1_grant", s_grant, 0);
        chk("t1_start", s_start, 0);
        // T2: highest index wins, lower one next cycle
        rst_n = 1;
        cyc(); chk("t2_grant_hi", s_grant, 2); retire();
        cyc(); chk("t2_grant_lo", s_grant, 1); chk("t2_tag1", s_tag, 6); retire();
        cyc(); chk("t2_tag0", s_tag, 1); chk("t2_start", s_start, 1);

        // T3: ch0 promoted on its 4th waiting cycle
        req[0] = 1; addr[0] = 16'h0300; req[1] = 1; addr[1] = 16'h0400;
        for (int k = 1; k <= 4; k++) begin
            cyc(); chk("t3_grant", s_grant, (k == 4) ? 1 : 2);
        end
        req[0] = 0; req[1] = 0;

        // T5: hold freezes the slot, release transfers and grants in one cycle
        req[0] = 1; addr[0] = 16'h0040;
        cyc(); chk("t5_grant0", s_grant, 1); retire();
        hold = 1; req[1] = 1; addr[1] = 16'h0080;
        for (int k = 0; k < 3; k++) begin
            cyc(); chk("t5_nogrant", s_grant, 0); chk("t5_addr_stable", s_addr, 16'h0040);
        end
        hold = 0;
        cyc(); chk("t5_regrant", s_grant, 2); retire();
        cyc(); chk("t5_next_addr", s_addr, 16'h0080);
        cyc(); chk("t5_drained", s_start, 0);

        // T6: lock-load by ch1 denies ch0 on the same word until the unlocking store
        req[1] = 1; cmd[1] = 0; lock[1] = 1; addr[1] = 16'h1234;
        cyc(); chk("t6_lock_grant", s_grant, 2); retire(); lock[1] = 0;
        req[0] = 1; cmd[0] = 0; addr[0] = 16'h1235;
        for (int k = 0; k < 2; k++) begin
            cyc(); chk("t6_deny", s_deny, 1); chk("t6_blocked", s_grant, 0);
        end
        req[1] = 1; cmd[1] = 1; addr[1] = 16'h1234;
        cyc(); chk("t6_store_grant", s_grant, 2); chk("t6_deny_same", s_deny, 1); retire();
        cyc(); chk("t6_ch0_grant", s_grant, 1); chk("t6_undeny", s_deny, 0); retire();

        repeat (300) begin rnd(); cyc(); end

        // round-robin instance
        rst_n = 0; hold = 0; sel = 1; n = 4; mode = 1;
        for (int i = 0; i < 4; i++) begin
            req[i] = 0; lock[i] = 0; unlock[i] = 0; cmd[i] = 0;
        end
        @(posedge clk); #1;
        reset_model();
        rst_n = 1;
        // T4: all request, grants rotate 1,2,3,0,1
        for (int i = 0; i < 4; i++) begin
            req[i] = 1; addr[i] = 16'(16'h0010 * (i + 1)); tag[i] = 2'(i);
        end
        for (int k = 0; k < 5; k++) begin
            cyc(); chk("t4_rr_grant", s_grant, 32'd1 << ((k + 1) % 4));
        end
        for (int i = 0; i < 4; i++) req[i] = 0;

        repeat (400) begin rnd(); cyc(); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
